fifo_to_sram_mover: RTL

- Sits directly downstream of the HPS-to-FPGA FIFO in the FPGA fabric.
- Polls the FIFO CSR fill level, drains words through the FIFO Avalon-MM out port, and writes them into on-chip SRAM port s1.
- Runs one transfer job per start command: base address plus word count.
- Reports busy, done, aborted and a running word count to fabric logic.

---
 rtl/fifo_mover_pkg.sv | 16 +
 rtl/fifo_to_sram_mover.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_mover_pkg.sv
// Shared types and constants for the HPS FIFO to on-chip SRAM mover.
package fifo_mover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEVEL_REQ,
    LEVEL_WAIT,
    BACKOFF,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [2:0] CSR_FILL_LEVEL_ADDR = 3'd0;
  localparam logic [3:0] BYTEEN_ALL          = 4'hF;

endpackage

// File: rtl/fifo_to_sram_mover.sv
// Drains the HPS-to-FPGA FIFO into SRAM s1, one job (base, length) per start.
// Polls the CSR fill level, reads up to min(level, remaining) words, writes each one cycle later.
//
// state      | meaning
// IDLE       | waiting for start; words_written holds last job's count
// LEVEL_REQ  | one-cycle CSR read of fill_level
// LEVEL_WAIT | fill level returned; size the burst
// BACKOFF    | FIFO empty; wait POLL_GAP cycles before re-polling
// DRAIN      | reading the burst; last write issues in the cycle burst hits 0
// FINISH     | one-cycle done/aborted pulse
module fifo_to_sram_mover
  import fifo_mover_pkg::*;
#(
  parameter int SRAM_AW  = 8,
  parameter int DW       = 32,
  parameter int LEVEL_W  = 9,
  parameter int POLL_GAP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SRAM_AW-1:0] base_addr,
  input  logic [SRAM_AW:0]   length,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [SRAM_AW:0]   words_written,
  output logic               fifo_read,
  input  logic [DW-1:0]      fifo_readdata,
  input  logic               fifo_waitrequest,
  output logic [2:0]         fifo_csr_address,
  output logic               fifo_csr_read,
  output logic               fifo_csr_write,
  output logic [31:0]        fifo_csr_writedata,
  input  logic [31:0]        fifo_csr_readdata,
  output logic [SRAM_AW-1:0] sram_address,
  output logic               sram_clken,
  output logic               sram_chipselect,
  output logic               sram_write,
  output logic [DW-1:0]      sram_writedata,
  output logic [3:0]         sram_byteenable
);

  localparam int CW = SRAM_AW + 1;
  localparam int MW = (LEVEL_W > CW) ? LEVEL_W : CW;
  localparam int BW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam logic [BW-1:0] GAP_LOAD = BW'(POLL_GAP - 1);

  state_t             state, state_n;
  logic [SRAM_AW-1:0] base_q;
  logic [CW-1:0]      remaining, burst, cnt, burst_load;
  logic [BW-1:0]      gap_cnt;
  logic               abort_pend, abort_seen, accept;
  logic               wr_pend;
  logic [DW-1:0]      wr_data;
  logic [MW-1:0]      level_x, rem_x, burst_calc;
  logic               unused_csr_bits;

  assign unused_csr_bits = ^fifo_csr_readdata[31:LEVEL_W];

  assign abort_seen = abort | abort_pend;
  assign accept     = (state == DRAIN) && (burst != '0) && !fifo_waitrequest;

  // Cap the burst at the job's remaining count so no word past the job is read.
  assign level_x    = MW'(fifo_csr_readdata[LEVEL_W-1:0]);
  assign rem_x      = MW'(remaining);
  assign burst_calc = (level_x < rem_x) ? level_x : rem_x;
  assign burst_load = CW'(burst_calc);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start) state_n = (length == '0) ? FINISH : LEVEL_REQ;
      LEVEL_REQ:  state_n = LEVEL_WAIT;
      LEVEL_WAIT: begin
        if (abort_seen)            state_n = FINISH;
        else if (burst_calc == '0) state_n = BACKOFF;
        else                       state_n = DRAIN;
      end
      BACKOFF: begin
        if (abort_seen)          state_n = FINISH;
        else if (gap_cnt == '0)  state_n = LEVEL_REQ;
      end
      DRAIN: begin
        if (burst == '0)
          state_n = (remaining == '0 || abort_seen) ? FINISH : LEVEL_REQ;
      end
      FINISH:     state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      remaining  <= '0;
      burst      <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      wr_pend    <= 1'b0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      wr_pend    <= accept;
      if (accept)  wr_data <= fifo_readdata;
      if (wr_pend) cnt <= cnt + CW'(1);
      abort_pend <= (state == IDLE || state == FINISH) ? 1'b0 : (abort_pend | abort);
      case (state)
        IDLE: if (start) begin
          base_q    <= base_addr;
          remaining <= length;
          cnt       <= '0;
        end
        LEVEL_WAIT: begin
          burst   <= burst_load;
          gap_cnt <= GAP_LOAD;
        end
        BACKOFF: if (gap_cnt != '0) gap_cnt <= gap_cnt - BW'(1);
        // An abort stops further reads but the honouring word is still written.
        DRAIN: if (accept) begin
          burst     <= abort_seen ? '0 : burst - CW'(1);
          remaining <= remaining - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == LEVEL_REQ) || (state == LEVEL_WAIT) ||
                   (state == BACKOFF)   || (state == DRAIN);
  assign done    = (state == FINISH) && (remaining == '0);
  assign aborted = (state == FINISH) && (remaining != '0);
  assign words_written = cnt;

  assign fifo_read          = (state == DRAIN) && (burst != '0);
  assign fifo_csr_address   = CSR_FILL_LEVEL_ADDR;
  assign fifo_csr_read      = (state == LEVEL_REQ);
  assign fifo_csr_write     = 1'b0;
  assign fifo_csr_writedata = '0;

  assign sram_write      = wr_pend;
  assign sram_clken      = wr_pend;
  assign sram_chipselect = wr_pend;
  assign sram_address    = wr_pend ? (base_q + cnt[SRAM_AW-1:0]) : '0;
  assign sram_writedata  = wr_pend ? wr_data : '0;
  assign sram_byteenable = wr_pend ? BYTEEN_ALL : 4'h0;

endmodule
